// File: rtl/io_fifo_port_if.sv
// io_fifo_port_if: I/O bus control and address signals for io_fifo_port.
// The 8-bit bidirectional data bus is a plain inout port on the design.
interface io_fifo_port_if #(
   parameter int AW = 16
);
   logic          sel;    // chip select from top-level I/O decode
   logic          ale;    // address latch enable (T1)
   logic          iom;    // 1 = I/O cycle, 0 = memory cycle
   logic          rd_n;   // read strobe, active low
   logic          wr_n;   // write strobe, active low
   logic [AW-1:0] addr;   // latched bus address

   modport master (output sel, ale, iom, rd_n, wr_n, addr);
   modport slave  (input  sel, ale, iom, rd_n, wr_n, addr);
endinterface

// File: rtl/io_fifo_port.sv
// io_fifo_port: byte FIFO behind a four-register I/O port.
// Registers by addr[1:0]: 0 DATA, 1 STATUS, 2 CONTROL, 3 COUNT.
// Optional feature: define IO_FIFO_IRQ_EN to add the registered irq output
// (high while the FIFO holds data, lagging occupancy by one clock).
module io_fifo_port #(
   parameter int DEPTH = 16,
   parameter int AW    = 16
) (
   input  logic           clk,
   input  logic           rst,
   io_fifo_port_if.slave  bus,
   inout  wire  [7:0]     data
`ifdef IO_FIFO_IRQ_EN
   ,
   output logic           irq
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ADDR   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [1:0] R_DATA   = 2'd0;
   localparam logic [1:0] R_STATUS = 2'd1;
   localparam logic [1:0] R_CTRL   = 2'd2;
   localparam logic [1:0] R_COUNT  = 2'd3;

   // Reject unsupported configurations at elaboration.
   if (DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("io_fifo_port: DEPTH must be a power of two in 4..64");
   end
   if (AW < 2) begin : g_bad_aw
      $error("io_fifo_port: AW must be at least 2");
   end

   logic [1:0]    state_q,   state_d;
   logic [1:0]    reg_sel_q, reg_sel_d;
   logic          is_wr_q,   is_wr_d;
   logic [7:0]    wdata_q,   wdata_d;
   logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
   logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
   logic [CW-1:0] count_q,   count_d;
   logic          ovf_q,     ovf_d;
   logic          unf_q,     unf_d;

   logic [7:0]    mem [DEPTH];
   logic          mem_we;
   logic          done_edge;
   logic          full, empty;
   logic          do_push, do_pop, do_ctrl;
   logic          drive_en;
   logic [7:0]    rdata;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // Bus-cycle sequencer: decode, strobe tracking and write-data capture.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      reg_sel_d = reg_sel_q;
      is_wr_d   = is_wr_q;
      wdata_d   = wdata_q;
      done_edge = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.ale && bus.sel && bus.iom) begin
               state_d   = S_ADDR;
               reg_sel_d = bus.addr[1:0];
            end
         end
         S_ADDR: begin
            // A strobe wins over a fresh ALE; ALE alone aborts the cycle.
            if (!bus.rd_n || !bus.wr_n) begin
               state_d = S_ACCESS;
               is_wr_d = !bus.wr_n;
            end else if (bus.ale) begin
               state_d = S_IDLE;
            end
         end
         S_ACCESS: begin
            if (!bus.wr_n) wdata_d = data;
            // Rise of the strobe that opened the access ends it.
            if (is_wr_q ? bus.wr_n : bus.rd_n) begin
               state_d   = S_DONE;
               done_edge = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign do_push = done_edge &&  is_wr_q && (reg_sel_q == R_DATA);
   assign do_pop  = done_edge && !is_wr_q && (reg_sel_q == R_DATA);
   assign do_ctrl = done_edge &&  is_wr_q && (reg_sel_q == R_CTRL);

   // FIFO bookkeeping: one push, pop or control action per bus cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      mem_we   = 1'b0;
      if (do_push) begin
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
         end
      end
      if (do_pop) begin
         if (empty) begin
            unf_d = 1'b1;
         end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
         end
      end
      if (do_ctrl) begin
         if (wdata_q[0]) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
         end
         if (wdata_q[1]) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
         end
      end
   end

   // Register read mux; an empty FIFO reads as zero.
   always_comb begin
      rdata = 8'h00;
      case (reg_sel_q)
         R_DATA:   rdata = empty ? 8'h00 : mem[rd_ptr_q];
         R_STATUS: rdata = {4'b0000, unf_q, ovf_q, full, empty};
         R_CTRL:   rdata = 8'h00;
         R_COUNT:  rdata = 8'(count_q);
         default:  rdata = 8'h00;
      endcase
   end

   assign drive_en = ((state_q == S_ADDR) || (state_q == S_ACCESS)) && !bus.rd_n;
   assign data     = drive_en ? rdata : 8'hzz;

   // Control and FIFO state registers.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         reg_sel_q <= 2'd0;
         is_wr_q   <= 1'b0;
         wdata_q   <= 8'h00;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         reg_sel_q <= reg_sel_d;
         is_wr_q   <= is_wr_d;
         wdata_q   <= wdata_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   // FIFO storage write port.
   // NOTE: storage has no reset; count/pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr_q] <= wdata_q;
   end

`ifdef IO_FIFO_IRQ_EN
   logic irq_q, irq_d;

   assign irq_d = (count_q != '0);
   assign irq   = irq_q;

   // Interrupt follows FIFO occupancy one clock late.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq_q <= 1'b0;
      else     irq_q <= irq_d;
   end
`endif

endmodule
